// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the image-processor serial link: receiver FSM
//   state encoding, default frame geometry and the image-upload request code.
//   No ports; imported by the receive sampler.
package uart_pkg;

    localparam int         UART_OVERSAMPLE = 16;
    localparam int         UART_DATA_BITS  = 8;
    localparam logic [7:0] UART_IMG_REQ    = 8'hF0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sampler_rx_sync.sv
// rx_sync
//   Metastability synchroniser for the asynchronous serial line. The chain
//   resets to 1 so that a reset never looks like a start bit.
// Ports
//   clk    in   system clock
//   clear  in   asynchronous active-low reset
//   rx     in   raw serial line (asynchronous)
//   rx_s   out  line after SYNC_STAGES flops
module rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clear,
    input  logic rx,
    output logic rx_s
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            chain <= '1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
//   Receive stage of the image-processor link. Recovers LSB-first 8N1 bytes
//   from the oversampled serial line using a three-sample majority vote
//   around the bit centre, with false-start rejection, framing-error and
//   overrun detection.
// Ports
//   clk_50m    in   system clock, all logic on posedge
//   clear      in   asynchronous active-low reset
//   rx         in   raw serial line, idle high
//   rx_clk_en  in   one-cycle strobe at OVERSAMPLE x baud
//   ready_clr  in   consumer ack; clears ready, frame_err, overrun
//   data_out   out  last good byte, held until the next good byte
//   ready      out  sticky: byte waiting in data_out
//   rx_busy    out  frame reception in progress
//   frame_err  out  sticky: stop bit sampled low
//   overrun    out  sticky: byte completed while ready was still set
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_50m,
    input  logic                 clear,
    input  logic                 rx,
    input  logic                 rx_clk_en,
    input  logic                 ready_clr,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 ready,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Vote window: ticks M-1, M, M+1 around the bit centre.
    localparam logic [TICK_W-1:0] TICK_VOTE_LO = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_VOTE_MD = TICK_W'(OVERSAMPLE / 2);
    localparam logic [TICK_W-1:0] TICK_VOTE_HI = TICK_W'(OVERSAMPLE / 2 + 1);
    localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST     = BIT_W'(DATA_BITS - 1);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    rx_state_t            state;
    logic                 rx_s;
    logic [TICK_W-1:0]    tick_cnt;
    logic [TICK_W-1:0]    tick_next;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 samp_lo;
    logic                 samp_md;
    logic                 vote;
    logic                 at_vote;
    logic [DATA_BITS-1:0] shreg;

    rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx_sync (
        .clk   (clk_50m),
        .clear (clear),
        .rx    (rx),
        .rx_s  (rx_s)
    );

    assign tick_next = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
    // The third vote sample is the live synchronised line at tick M+1.
    assign vote      = maj3(samp_lo, samp_md, rx_s);
    assign at_vote   = rx_clk_en && (tick_cnt == TICK_VOTE_HI);

    // Sample and shift registers carry data only; they are always rewritten
    // before being consumed, so they need no reset.
    always_ff @(posedge clk_50m) begin
        if (rx_clk_en && (state != IDLE) && (state != BREAK)) begin
            if (tick_cnt == TICK_VOTE_LO) samp_lo <= rx_s;
            if (tick_cnt == TICK_VOTE_MD) samp_md <= rx_s;
        end
        if (at_vote && (state == DATA)) begin
            shreg <= {vote, shreg[DATA_BITS-1:1]};
        end
    end

    // ---- FSM, counters and sticky flags ----
    always_ff @(posedge clk_50m or negedge clear) begin
        if (!clear) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            rx_busy   <= 1'b0;
            data_out  <= '0;
            ready     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // Ack first; any flag set below in the same cycle overrides it.
            if (ready_clr) begin
                ready     <= 1'b0;
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end

            if (rx_clk_en) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            tick_cnt <= '0;
                            rx_busy  <= 1'b1;
                            state    <= START;
                        end
                    end
                    START: begin
                        tick_cnt <= tick_next;
                        if (tick_cnt == TICK_VOTE_HI && vote) begin
                            // Glitch shorter than half a bit: not a real start.
                            rx_busy <= 1'b0;
                            state   <= IDLE;
                        end else if (tick_cnt == TICK_LAST) begin
                            bit_cnt <= '0;
                            state   <= DATA;
                        end
                    end
                    DATA: begin
                        tick_cnt <= tick_next;
                        if (tick_cnt == TICK_LAST) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == BIT_LAST) begin
                                state <= STOP;
                            end
                        end
                    end
                    STOP: begin
                        tick_cnt <= tick_next;
                        if (tick_cnt == TICK_VOTE_HI) begin
                            if (vote) begin
                                data_out <= shreg;
                                ready    <= 1'b1;
                                if (ready) overrun <= 1'b1;
                                rx_busy  <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= BREAK;
                            end
                        end
                    end
                    BREAK: begin
                        // A line held low must return high before re-framing.
                        if (rx_s) begin
                            rx_busy <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                    default: begin
                        rx_busy <= 1'b0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler
//   Drives serial frames tick by tick and compares the sampler's outputs
//   against a frame-level reference of the receiver's externally visible state.
module tb_uart_rx_sampler;
    import uart_pkg::*;

    localparam int OS = 16;

    logic       clk_50m = 1'b0;
    logic       clear;
    logic       rx;
    logic       rx_clk_en;
    logic       ready_clr;
    logic [7:0] data_out;
    logic       ready;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    int n_cmp = 0;
    int n_mis = 0;
    bit jitter = 1'b0;

    // Reference: what the consumer should see after each whole frame.
    logic [7:0] m_data;
    logic       m_ready, m_ferr, m_ovr;

    uart_rx_sampler dut (
        .clk_50m   (clk_50m),
        .clear     (clear),
        .rx        (rx),
        .rx_clk_en (rx_clk_en),
        .ready_clr (ready_clr),
        .data_out  (data_out),
        .ready     (ready),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #10 clk_50m = ~clk_50m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_data = 8'h00; m_ready = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit stop);
        if (stop) begin
            if (m_ready) m_ovr = 1'b1;
            m_ready = 1'b1;
            m_data  = b;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic model_clr();
        m_ready = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    endtask

    // One oversample tick: strobe for one clock, then idle. When follow is
    // set, ready_clr is held high for as long as ready is low, so it is
    // asserted in exactly the cycle ready gets set.
    task automatic do_tick(input bit follow);
        int extra;
        extra = 0;
        if (jitter && $urandom_range(0, 7) == 0) extra = $urandom_range(1, 20);
        @(negedge clk_50m);
        rx_clk_en = 1'b1;
        if (follow) ready_clr = !ready;
        @(negedge clk_50m);
        rx_clk_en = 1'b0;
        if (follow) ready_clr = !ready;
        repeat (2 + extra) begin
            @(negedge clk_50m);
            if (follow) ready_clr = !ready;
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) do_tick(1'b0);
    endtask

    task automatic line_idle(input int n);
        rx = 1'b1;
        ticks(n);
    endtask

    task automatic send_frame(input string tag, input logic [7:0] b, input bit stop, input bit follow);
        int busy_low;
        busy_low = 0;
        rx = 1'b0;
        ticks(OS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            ticks(OS);
            if (!rx_busy) busy_low++;
        end
        rx = stop;
        repeat (OS) do_tick(follow);
        ready_clr = 1'b0;
        chk({tag, ".busy_in_frame"}, busy_low, 0);
    endtask

    task automatic pulse_clr();
        @(negedge clk_50m);
        ready_clr = 1'b1;
        @(negedge clk_50m);
        ready_clr = 1'b0;
        model_clr();
    endtask

    task automatic check_out(input string tag);
        chk({tag, ".data_out"},  data_out,  m_data);
        chk({tag, ".ready"},     ready,     m_ready);
        chk({tag, ".frame_err"}, frame_err, m_ferr);
        chk({tag, ".overrun"},   overrun,   m_ovr);
        chk({tag, ".rx_busy"},   rx_busy,   1'b0);
    endtask

    initial begin
        #(20 * 95000);
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        bit         stop;
        int         busy_seen;

        clear = 1'b0; rx = 1'b1; rx_clk_en = 1'b0; ready_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_50m);
        check_out("reset");
        clear = 1'b1;
        line_idle(4);

        // Basic frame.
        send_frame("a5", 8'hA5, 1'b1, 1'b0);
        model_frame(8'hA5, 1'b1);
        line_idle(2);
        check_out("a5");
        pulse_clr();
        chk("a5.ack_ready", ready, m_ready);

        // False start: a five-tick low pulse must not frame a byte.
        rx = 1'b0;
        ticks(5);
        chk("fstart.busy_pulse", rx_busy, 1'b1);
        line_idle(OS);
        check_out("fstart");
        send_frame("3c", 8'h3C, 1'b1, 1'b0);
        model_frame(8'h3C, 1'b1);
        line_idle(2);
        check_out("3c");
        pulse_clr();

        // Framing error, then a long break that must not be re-framed.
        send_frame("55", 8'h55, 1'b0, 1'b0);
        model_frame(8'h55, 1'b0);
        rx = 1'b0;
        ticks(40);
        chk("break.busy",      rx_busy,   1'b1);
        chk("break.ready",     ready,     1'b0);
        chk("break.frame_err", frame_err, 1'b1);
        chk("break.data_out",  data_out,  8'h3C);
        line_idle(4);
        check_out("55");
        pulse_clr();

        // Overrun.
        send_frame("12", 8'h12, 1'b1, 1'b0);
        model_frame(8'h12, 1'b1);
        line_idle(1);
        send_frame("34", 8'h34, 1'b1, 1'b0);
        model_frame(8'h34, 1'b1);
        line_idle(2);
        check_out("ovr");
        pulse_clr();
        check_out("ovr_ack");

        // Ack coincident with the set: set must win.
        send_frame("f0", UART_IMG_REQ, 1'b1, 1'b1);
        model_frame(UART_IMG_REQ, 1'b1);
        line_idle(2);
        check_out("f0_setwins");

        // Reset in the middle of data bit 4 of 0xFF.
        rx = 1'b0;
        ticks(OS);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            ticks(OS);
        end
        rx = 1'b1;
        ticks(8);
        @(negedge clk_50m);
        clear = 1'b0;
        #1;
        model_reset();
        check_out("midreset");
        repeat (2) @(negedge clk_50m);
        clear = 1'b1;
        line_idle(20);
        check_out("post_reset");
        send_frame("81", 8'h81, 1'b1, 1'b0);
        model_frame(8'h81, 1'b1);
        line_idle(2);
        check_out("81");

        // Randomised frames with strobe gaps, framing errors, back-to-back
        // frames and random acks.
        jitter = 1'b1;
        for (int n = 0; n < 24; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            send_frame("rnd", b, stop, 1'b0);
            model_frame(b, stop);
            if (stop) begin
                line_idle($urandom_range(0, 2));
            end else begin
                rx = 1'b0;
                ticks($urandom_range(0, 20));
                busy_seen = int'(rx_busy);
                chk("rnd.break_busy", busy_seen, 1);
                line_idle(4);
            end
            check_out("rnd");
            if ($urandom_range(0, 2) == 0) begin
                pulse_clr();
                check_out("rnd_ack");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
